// File: rtl/dcache_pkg.sv
// Shared types, geometry and address-field helpers for the direct-mapped data cache.
package dcache_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned LINE_WORDS = 4;
    localparam int unsigned NUM_LINES  = 32;

    localparam int unsigned OFF_W      = $clog2(LINE_WORDS);
    localparam int unsigned IDX_W      = $clog2(NUM_LINES);
    localparam int unsigned BYTE_OFF_W = OFF_W + 2;
    localparam int unsigned TAG_W      = ADDR_W - IDX_W - BYTE_OFF_W;
    localparam int unsigned LINE_W     = LINE_WORDS * DATA_W;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_ALLOCATE  = 2'd2
    } state_e;

    function automatic logic [OFF_W-1:0] addr_off(input logic [ADDR_W-1:0] addr);
        return OFF_W'(addr >> 2);
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] addr);
        return IDX_W'(addr >> BYTE_OFF_W);
    endfunction

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
        return TAG_W'(addr >> (ADDR_W - TAG_W));
    endfunction

    // Rebuild a line-aligned byte address from its tag and index.
    function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                    input logic [IDX_W-1:0] idx);
        return {tag, idx, BYTE_OFF_W'(0)};
    endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Tag/valid/dirty/data storage: async read, synchronous writes, valid/dirty cleared on reset.
module dcache_line_array
    import dcache_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [IDX_W-1:0]  idx,
    output logic              rd_valid,
    output logic              rd_dirty,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [LINE_W-1:0] rd_line,
    input  logic              word_we,
    input  logic [OFF_W-1:0]  word_off,
    input  logic [DATA_W-1:0] word_data,
    input  logic              fill_we,
    input  logic [TAG_W-1:0]  fill_tag,
    input  logic [LINE_W-1:0] fill_line,
    input  logic              clean_we
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_W-1:0]    data_q [NUM_LINES];

    assign rd_valid = valid_q[idx];
    assign rd_dirty = dirty_q[idx];
    assign rd_tag   = tag_q[idx];
    assign rd_line  = data_q[idx];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_we) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end else if (clean_we) begin
            dirty_q[idx] <= 1'b0;
        end else if (word_we) begin
            dirty_q[idx] <= 1'b1;
        end
    end

    // Tags and data are not reset; the enables are already qualified by reset.
    always_ff @(posedge clk_i) begin
        if (fill_we) begin
            tag_q[idx]  <= fill_tag;
            data_q[idx] <= fill_line;
        end else if (word_we) begin
            data_q[idx][DATA_W*int'(word_off) +: DATA_W] <= word_data;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache controller.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache_ctrl
    import dcache_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_wdata_o,
    input  logic [LINE_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
`endif
);

    state_e state_q;

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [OFF_W-1:0]  req_off;
    logic              rd_valid;
    logic              rd_dirty;
    logic [TAG_W-1:0]  rd_tag;
    logic [LINE_W-1:0] rd_line;
    logic              in_idle;
    logic              hit;
    logic              miss;
    logic              word_we;
    logic              fill_we;
    logic              clean_we;

    assign req_tag = addr_tag(cpu_addr_i);
    assign req_idx = addr_idx(cpu_addr_i);
    assign req_off = addr_off(cpu_addr_i);

    assign in_idle  = (state_q == S_IDLE) && !rst_i;
    assign hit      = in_idle && cpu_req_i && rd_valid && (rd_tag == req_tag);
    assign miss     = in_idle && cpu_req_i && !hit;
    assign word_we  = hit && cpu_we_i;
    assign fill_we  = !rst_i && (state_q == S_ALLOCATE) && mem_ack_i;
    assign clean_we = !rst_i && (state_q == S_WRITEBACK) && mem_ack_i;

    // The CPU holds its request during a miss, so one index serves every access.
    dcache_line_array u_lines (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .idx       (req_idx),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .rd_tag    (rd_tag),
        .rd_line   (rd_line),
        .word_we   (word_we),
        .word_off  (req_off),
        .word_data (cpu_wdata_i),
        .fill_we   (fill_we),
        .fill_tag  (req_tag),
        .fill_line (mem_rdata_i),
        .clean_we  (clean_we)
    );

    // Miss FSM; acks outside the memory states fall through the default arms.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:      if (miss) state_q <= (rd_valid && rd_dirty) ? S_WRITEBACK : S_ALLOCATE;
                S_WRITEBACK: if (mem_ack_i) state_q <= S_ALLOCATE;
                S_ALLOCATE:  if (mem_ack_i) state_q <= S_IDLE;
                default:     state_q <= S_IDLE;
            endcase
        end
    end

    // CPU and memory side outputs decoded from the registered state and hit logic.
    always_comb begin
        cpu_rdata_o = '0;
        cpu_stall_o = miss;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        if (hit) begin
            cpu_rdata_o = rd_line[DATA_W*int'(req_off) +: DATA_W];
        end
        if (!rst_i) begin
            case (state_q)
                S_WRITEBACK: begin
                    cpu_stall_o = 1'b1;
                    mem_req_o   = 1'b1;
                    mem_we_o    = 1'b1;
                    mem_addr_o  = line_addr(rd_tag, req_idx);
                end
                S_ALLOCATE: begin
                    cpu_stall_o = 1'b1;
                    mem_req_o   = 1'b1;
                    mem_addr_o  = line_addr(req_tag, req_idx);
                end
                default: ;
            endcase
        end
    end

    assign mem_wdata_o = rd_line;

`ifdef DCACHE_STATS_EN
    logic refill_q;

    // The hit that completes a refilled miss is not counted as a hit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            refill_q   <= 1'b0;
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else begin
            refill_q <= fill_we;
            if (hit && !refill_q) hit_cnt_o <= hit_cnt_o + 32'd1;
            if (miss) miss_cnt_o <= miss_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl against a line-level cache/memory model.
// Stats outputs are checked when DCACHE_STATS_EN is defined.
module tb_dcache_ctrl;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         cpu_req_i = 1'b0;
    logic         cpu_we_i = 1'b0;
    logic [31:0]  cpu_addr_i = '0;
    logic [31:0]  cpu_wdata_i = '0;
    logic [31:0]  cpu_rdata_o;
    logic         cpu_stall_o;
    logic         mem_req_o;
    logic         mem_we_o;
    logic [31:0]  mem_addr_o;
    logic [127:0] mem_wdata_o;
    logic [127:0] mem_rdata_i = '0;
    logic         mem_ack_i = 1'b0;
`ifdef DCACHE_STATS_EN
    logic [31:0]  hit_cnt_o;
    logic [31:0]  miss_cnt_o;
`endif

    always #5 clk_i = ~clk_i;

    dcache_ctrl dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cpu_req_i   (cpu_req_i),
        .cpu_we_i    (cpu_we_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_wdata_i (cpu_wdata_i),
        .cpu_rdata_o (cpu_rdata_o),
        .cpu_stall_o (cpu_stall_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt_o   (hit_cnt_o),
        .miss_cnt_o  (miss_cnt_o)
`endif
    );

    // Reference model: per-line state plus a backing memory of whole lines.
    bit           m_valid [32];
    bit           m_dirty [32];
    int unsigned  m_tag   [32];
    logic [31:0]  m_data  [32][4];
    logic [127:0] mem_img [int unsigned];
    int           exp_hits;
    int           exp_misses;
    int           checks;
    int           errors;

    function automatic logic [127:0] mem_line(input int unsigned la);
        if (!mem_img.exists(la)) mem_img[la] = {$urandom, $urandom, $urandom, $urandom};
        return mem_img[la];
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        exp_hits   = 0;
        exp_misses = 0;
    endfunction

    // Entered #1 after an edge with the memory request expected visible.
    task automatic mem_txn(input logic exp_we, input logic [31:0] exp_addr, input logic [127:0] exp_wdata,
                           input logic [127:0] fill, input int delay, inout int stalls);
        checks++;
        if (mem_req_o !== 1'b1) begin errors++; $display("FAIL mem_req got %b want 1", mem_req_o); end
        checks++;
        if (mem_we_o !== exp_we) begin errors++; $display("FAIL mem_we got %b want %b", mem_we_o, exp_we); end
        checks++;
        if (mem_addr_o !== exp_addr) begin errors++; $display("FAIL mem_addr got %h want %h", mem_addr_o, exp_addr); end
        if (exp_we) begin
            checks++;
            if (mem_wdata_o !== exp_wdata) begin
                errors++; $display("FAIL mem_wdata got %h want %h", mem_wdata_o, exp_wdata);
            end
        end
        if (cpu_stall_o === 1'b1) stalls++;
        for (int i = 0; i < delay; i++) begin
            @(posedge clk_i); #1;
            checks++;
            if (mem_req_o !== 1'b1) begin errors++; $display("FAIL mem_req_hold got %b want 1", mem_req_o); end
            if (cpu_stall_o === 1'b1) stalls++;
        end
        @(negedge clk_i);
        mem_ack_i   = 1'b1;
        mem_rdata_i = fill;
        @(posedge clk_i); #1;
        mem_ack_i   = 1'b0;
        mem_rdata_i = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // One CPU access, including any miss handling, checked against the model.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input int dly_wb, input int dly_fill);
        int unsigned idx = (addr >> 4) % 32;
        int unsigned tg  = addr >> 9;
        int unsigned w   = (addr >> 2) % 4;
        bit hit_e = m_valid[idx] && (m_tag[idx] == tg);
        bit wb_e  = !hit_e && m_valid[idx] && m_dirty[idx];
        int stalls = 0;
        int exp_stalls;
        logic [31:0]  la;
        logic [127:0] line;
        @(negedge clk_i);
        cpu_req_i   = 1'b1;
        cpu_we_i    = we;
        cpu_addr_i  = addr;
        cpu_wdata_i = wd;
        #1;
        if (!hit_e) begin
            exp_misses++;
            checks++;
            if (cpu_stall_o !== 1'b1) begin errors++; $display("FAIL miss_stall %h got %b want 1", addr, cpu_stall_o); end
            checks++;
            if (cpu_rdata_o !== 32'h0) begin errors++; $display("FAIL miss_rdata %h got %h want 0", addr, cpu_rdata_o); end
            if (cpu_stall_o === 1'b1) stalls++;
            @(posedge clk_i); #1;
            if (wb_e) begin
                la   = 32'((m_tag[idx] << 9) | (idx << 4));
                line = {m_data[idx][3], m_data[idx][2], m_data[idx][1], m_data[idx][0]};
                mem_img[la] = line;
                mem_txn(1'b1, la, line, '0, dly_wb, stalls);
            end
            la   = 32'((tg << 9) | (idx << 4));
            line = mem_line(la);
            mem_txn(1'b0, la, '0, line, dly_fill, stalls);
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_tag[idx]   = tg;
            for (int k = 0; k < 4; k++) m_data[idx][k] = line[32*k +: 32];
            exp_stalls = 1 + (dly_fill + 1) + (wb_e ? dly_wb + 1 : 0);
            checks++;
            if (stalls !== exp_stalls) begin errors++; $display("FAIL stall_cycles %h got %0d want %0d", addr, stalls, exp_stalls); end
        end else begin
            exp_hits++;
            checks++;
            if (mem_req_o !== 1'b0) begin errors++; $display("FAIL hit_mem_req %h got %b want 0", addr, mem_req_o); end
        end
        checks++;
        if (cpu_stall_o !== 1'b0) begin errors++; $display("FAIL done_stall %h got %b want 0", addr, cpu_stall_o); end
        if (!we) begin
            checks++;
            if (cpu_rdata_o !== m_data[idx][w]) begin
                errors++; $display("FAIL load %h got %h want %h", addr, cpu_rdata_o, m_data[idx][w]);
            end
        end else begin
            m_data[idx][w] = wd;
            m_dirty[idx]   = 1'b1;
        end
        @(posedge clk_i);
    endtask

    task automatic check_stats(input string name);
`ifdef DCACHE_STATS_EN
        #1;
        checks++;
        if (hit_cnt_o !== 32'(exp_hits)) begin errors++; $display("FAIL %s hit_cnt got %0d want %0d", name, hit_cnt_o, exp_hits); end
        checks++;
        if (miss_cnt_o !== 32'(exp_misses)) begin errors++; $display("FAIL %s miss_cnt got %0d want %0d", name, miss_cnt_o, exp_misses); end
`else
        if (name.len() == 0) $display("stats disabled");
`endif
    endtask

    task automatic test_reset();
        rst_i      = 1'b1;
        cpu_req_i  = 1'b1;
        cpu_addr_i = 32'h100;
        repeat (2) @(posedge clk_i);
        #1;
        checks++;
        if (cpu_stall_o !== 1'b0) begin errors++; $display("FAIL rst_stall got %b want 0", cpu_stall_o); end
        checks++;
        if (mem_req_o !== 1'b0) begin errors++; $display("FAIL rst_mem_req got %b want 0", mem_req_o); end
        checks++;
        if (mem_we_o !== 1'b0) begin errors++; $display("FAIL rst_mem_we got %b want 0", mem_we_o); end
        checks++;
        if (mem_addr_o !== 32'h0) begin errors++; $display("FAIL rst_mem_addr got %h want 0", mem_addr_o); end
        checks++;
        if (cpu_rdata_o !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h want 0", cpu_rdata_o); end
        @(negedge clk_i);
        rst_i     = 1'b0;
        cpu_req_i = 1'b0;
        model_reset();
        check_stats("reset");
    endtask

    task automatic test_directed();
        mem_img[32'h100] = {32'd4, 32'd3, 32'd2, 32'd1};
        access(1'b0, 32'h100, 32'h0, 0, 3);
        access(1'b0, 32'h10C, 32'h0, 0, 0);
        access(1'b1, 32'h104, 32'hDEAD, 0, 0);
        access(1'b0, 32'h104, 32'h0, 0, 0);
        access(1'b0, 32'h300, 32'h0, 0, 0);
        checks++;
        if (mem_img[32'h100][63:32] !== 32'hDEAD) begin
            errors++; $display("FAIL wb_word1 got %h want dead", mem_img[32'h100][63:32]);
        end
        check_stats("directed");
    endtask

    task automatic test_reset_mid_alloc();
        @(negedge clk_i);
        cpu_req_i  = 1'b1;
        cpu_we_i   = 1'b0;
        cpu_addr_i = 32'h500;
        #1;
        checks++;
        if (cpu_stall_o !== 1'b1) begin errors++; $display("FAIL mid_stall got %b want 1", cpu_stall_o); end
        @(posedge clk_i); #1;
        checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h500 || mem_we_o !== 1'b0) begin
            errors++; $display("FAIL mid_alloc req %b we %b addr %h want 1 0 00000500", mem_req_o, mem_we_o, mem_addr_o);
        end
        @(negedge clk_i);
        rst_i     = 1'b1;
        cpu_req_i = 1'b0;
        @(posedge clk_i); #1;
        checks++;
        if (mem_req_o !== 1'b0) begin errors++; $display("FAIL mid_rst_req got %b want 0", mem_req_o); end
        @(negedge clk_i);
        rst_i = 1'b0;
        model_reset();
        access(1'b0, 32'h300, 32'h0, 0, 1);
        check_stats("mid_reset");
    endtask

    task automatic test_spurious_ack();
        @(negedge clk_i);
        cpu_req_i = 1'b0;
        mem_ack_i = 1'b1;
        @(posedge clk_i); #1;
        mem_ack_i = 1'b0;
        checks++;
        if (mem_req_o !== 1'b0 || cpu_stall_o !== 1'b0) begin
            errors++; $display("FAIL idle_ack req %b stall %b want 0 0", mem_req_o, cpu_stall_o);
        end
        access(1'b0, 32'h304, 32'h0, 0, 0);
    endtask

    task automatic test_random();
        int unsigned idx_pick [4] = '{0, 1, 16, 31};
        logic [31:0] a;
        for (int n = 0; n < 200; n++) begin
            a = 32'(($urandom_range(0, 3) << 9) | (idx_pick[$urandom_range(0, 3)] << 4)
                    | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3));
            access(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) begin
                @(negedge clk_i);
                cpu_req_i = 1'b0;
                #1;
                checks++;
                if (cpu_stall_o !== 1'b0 || cpu_rdata_o !== 32'h0) begin
                    errors++; $display("FAIL no_req stall %b rdata %h want 0 0", cpu_stall_o, cpu_rdata_o);
                end
            end
        end
        check_stats("random");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_reset();
        test_reset();
        test_directed();
        test_reset_mid_alloc();
        test_spurious_ack();
        test_random();
        @(negedge clk_i);
        cpu_req_i = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
